aibnd_avmm2_txsched: RTL and testbench
======================================

Name: aibnd_avmm2_txsched

Overview:
Transmit scheduler for the AVMM2 sideband TX pair (two DDR output buffers, 4 bits per clock). It arbitrates round-robin between two requesters, each offering a DATA_W-bit word, and frames each word as one header beat followed by DATA_W/4 payload beats. It also sequences the buffer enables: itxen warm-up on link enable, data-select, and drain-then-disable. It sits between the AVMM2 sideband logic and the buffer inputs avmm2_idat0/avmm2_idat1/itxen/idataselb.

Parameters:
DATA_W, 16, payload width per frame; must be a multiple of 4 and at least 4. BEATS = DATA_W/4.
WARM_CYC, 8, cycles itxen is held high with idle data before the link reports ready; range 1..255.
GAP_CYC, 1, idle beats forced between consecutive frames; range 0..15.

Ports:
avmm_clk  input  1  block clock; all state updates on rising edge
avmm_sync_rstb  input  1  reset, asynchronous assert, active-low
link_en  input  1  level; high requests the TX pads be enabled
req_valid  input  2  per-requester valid; held until the matching ready
req_data0  input  DATA_W  requester 0 word; stable while req_valid[0] is high
req_data1  input  DATA_W  requester 1 word; stable while req_valid[1] is high
req_ready  output  2  one-cycle grant/accept pulse; transfer occurs on the edge where valid&ready
avmm2_idat0  output  2  DDR phase-0 data to TX buffers [1:0]
avmm2_idat1  output  2  DDR phase-1 data to TX buffers [1:0]
itxen  output  1  TX buffer output enable
idataselb  output  1  0 = sync DDR path selected, 1 = parked
link_rdy  output  1  high in IDLE/HDR/DATA/GAP
busy  output  1  high in HDR/DATA/GAP
frame_cnt  output  8  frames completed; wraps 255->0

Behaviour:
- Reset: state OFF. All outputs are registered. Reset values: avmm2_idat0=avmm2_idat1=2'b00, itxen=0, idataselb=1, req_ready=2'b00, link_rdy=0, busy=0, frame_cnt=0. The RR pointer is reset so that requester 0 wins first.
- States: OFF, WARM, IDLE, HDR, DATA, GAP. Outputs reflect the current state in the same cycle.
- OFF:
  - itxen=0, idataselb=1, pads 0.
  - If link_en=1, go to WARM and load the warm counter with WARM_CYC.
- WARM:
  - itxen=1, idataselb=0, pads 0. The counter decrements each cycle.
  - When the counter reaches 1, go to IDLE. The total dwell is exactly WARM_CYC cycles.
  - If link_en=0, go to OFF.
- IDLE:
  - Pads 0.
  - If link_en=0, go to OFF. Disable has priority over requests.
  - Otherwise, if any req_valid is high, grant one and go to HDR.
  - Arbitration: if both are valid, grant the requester not granted last. If one is valid, grant it. The pointer updates on grant.
- HDR (1 cycle):
  - req_ready[grant]=1.
  - avmm2_idat0=2'b11 (start marker).
  - avmm2_idat1[0]=grant id.
  - avmm2_idat1[1]=even parity (XOR) of the granted data.
  - Data is captured into the shift register at the end of the cycle. Go to DATA with beat count 0.
- DATA (BEATS cycles):
  - Nibble n = data[4n+3:4n], LSB nibble first.
  - Bit mapping: avmm2_idat0[0]=bit0, avmm2_idat1[0]=bit1, avmm2_idat0[1]=bit2, avmm2_idat1[1]=bit3.
  - On the last beat, frame_cnt increments. Then go to GAP if GAP_CYC>0; otherwise go to HDR if a request is pending and link_en=1, otherwise to IDLE/OFF per link_en.
- GAP (GAP_CYC cycles):
  - Pads 0.
  - Exits like IDLE: link_en=0 goes to OFF. A pending request goes directly to HDR on the last gap cycle.
- link_en falling during HDR/DATA/GAP: the frame in flight completes (drain), then the FSM goes to OFF. itxen drops only on entry to OFF, never mid-frame.
- Requests are not sampled outside IDLE and the GAP/DATA exit decision. req_valid dropping without ready is allowed: it is a no-op and no frame is sent.
- Latency: req_valid is sampled in IDLE at edge k. HDR is in cycle k+1. Payload occupies cycles k+2..k+1+BEATS. Minimum frame-to-frame period is 1+BEATS+GAP_CYC.
- Async reset mid-frame: immediate return to reset values. No partial-frame completion.

Test Plan:
- Bring-up: WARM_CYC=8, assert link_en at cycle 0 -> itxen=1 and idataselb=0 from cycle 1; link_rdy rises at cycle 9; pads 0 throughout.
- Single frame: req_valid=2'b01, req_data0=16'hA5C3 -> HDR idat0=11, idat1=2'b00 (id 0, parity 0). Then 4 beats of nibbles 3,C,5,A mapped per bit rule; req_ready[0] pulses once; frame_cnt=1.
- Arbitration: both valid continuously with GAP_CYC=1 -> grants alternate 0,1,0,1. Frames are spaced 6 cycles apart. Header idat1[0] toggles each frame.
- Back-to-back with GAP_CYC=0: req1 held valid -> HDR immediately follows the last DATA beat with no idle beat. req_data1=16'h0001 gives parity bit 1.
- Drain: drop link_en during DATA beat 1 -> remaining beats are sent, then OFF. itxen falls in the cycle after the last beat. A pending req_valid gets no ready.
- Reset mid-frame plus counter wrap: assert avmm_sync_rstb=0 during DATA -> all outputs return to reset values asynchronously. A separate run of 256 frames -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/aibnd_avmm2_txsched_if.sv
// ----------------------------------------------------------------------------
// aibnd_avmm2_txsched_if : two-requester word bus into the AVMM2 TX scheduler
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface aibnd_avmm2_txsched_if #(
    parameter int DATA_W = 16
);
    logic [1:0]        req_valid;
    logic [DATA_W-1:0] req_data0;
    logic [DATA_W-1:0] req_data1;
    logic [1:0]        req_ready;

    modport master (
        output req_valid,
        output req_data0,
        output req_data1,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data0,
        input  req_data1,
        output req_ready
    );
endinterface

`default_nettype wire

// File: rtl/aibnd_avmm2_txsched.sv
// ----------------------------------------------------------------------------
// aibnd_avmm2_txsched : AVMM2 sideband TX scheduler (RR arbitration, framing, enables)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module aibnd_avmm2_txsched #(
    parameter int DATA_W   = 16,
    parameter int WARM_CYC = 8,
    parameter int GAP_CYC  = 1
) (
    input  logic                    avmm_clk,
    input  logic                    avmm_sync_rstb,
    input  logic                    link_en,
    aibnd_avmm2_txsched_if.slave    req,
    output logic [1:0]              avmm2_idat0,
    output logic [1:0]              avmm2_idat1,
    output logic                    itxen,
    output logic                    idataselb,
    output logic                    link_rdy,
    output logic                    busy,
    output logic [7:0]              frame_cnt
);

    localparam int BEATS  = DATA_W / 4;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [2:0] {
        S_OFF  = 3'd0,
        S_WARM = 3'd1,
        S_IDLE = 3'd2,
        S_HDR  = 3'd3,
        S_DATA = 3'd4,
        S_GAP  = 3'd5
    } state_t;

    state_t              state, state_nx;
    logic [7:0]          warm_cnt, warm_cnt_nx;
    logic [3:0]          gap_cnt, gap_cnt_nx;
    logic [BEAT_W-1:0]   beat, beat_nx;
    logic                grant, grant_nx;
    logic                last_grant, last_grant_nx;
    logic [DATA_W-1:0]   shreg, shreg_nx;
    logic [7:0]          frame_cnt_nx;
    logic                launch;
    logic                any_valid;
    logic                pick;
    logic [DATA_W-1:0]   pick_data;

    logic [1:0]          idat0_nx, idat1_nx, ready_nx;
    logic                itxen_nx, idataselb_nx, link_rdy_nx, busy_nx;

    // Contention goes to whoever was not served last; a lone requester always wins.
    assign any_valid = |req.req_valid;
    assign pick      = (req.req_valid == 2'b11) ? ~last_grant : req.req_valid[1];
    assign pick_data = pick ? req.req_data1 : req.req_data0;

    always_comb begin
        state_nx      = state;
        warm_cnt_nx   = warm_cnt;
        gap_cnt_nx    = gap_cnt;
        beat_nx       = beat;
        grant_nx      = grant;
        last_grant_nx = last_grant;
        shreg_nx      = shreg;
        frame_cnt_nx  = frame_cnt;
        launch        = 1'b0;

        case (state)
            S_OFF: begin
                if (link_en) begin
                    state_nx    = S_WARM;
                    warm_cnt_nx = 8'(WARM_CYC);
                end
            end
            S_WARM: begin
                if (!link_en) begin
                    state_nx = S_OFF;
                end else if (warm_cnt == 8'd1) begin
                    state_nx = S_IDLE;
                end else begin
                    warm_cnt_nx = warm_cnt - 8'd1;
                end
            end
            S_IDLE: begin
                if (!link_en) begin
                    state_nx = S_OFF;
                end else if (any_valid) begin
                    launch = 1'b1;
                end
            end
            S_HDR: begin
                state_nx = S_DATA;
                beat_nx  = '0;
                shreg_nx = grant ? req.req_data1 : req.req_data0;
            end
            S_DATA: begin
                shreg_nx = shreg >> 4;
                if (beat == BEAT_W'(BEATS - 1)) begin
                    frame_cnt_nx = frame_cnt + 8'd1;
                    // A disable seen at the end of a frame skips the gap and shuts down.
                    if (!link_en) begin
                        state_nx = S_OFF;
                    end else if (GAP_CYC > 0) begin
                        state_nx   = S_GAP;
                        gap_cnt_nx = 4'(GAP_CYC);
                    end else if (any_valid) begin
                        launch = 1'b1;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end else begin
                    beat_nx = beat + BEAT_W'(1);
                end
            end
            S_GAP: begin
                if (!link_en) begin
                    state_nx = S_OFF;
                end else if (gap_cnt == 4'd1) begin
                    if (any_valid) begin
                        launch = 1'b1;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end else begin
                    gap_cnt_nx = gap_cnt - 4'd1;
                end
            end
            default: begin
                state_nx = S_OFF;
            end
        endcase

        if (launch) begin
            state_nx      = S_HDR;
            grant_nx      = pick;
            last_grant_nx = pick;
        end
    end

    // Outputs are decoded from the next state so the registered pads line up with it.
    always_comb begin
        idat0_nx = 2'b00;
        idat1_nx = 2'b00;
        ready_nx = 2'b00;
        case (state_nx)
            S_HDR: begin
                idat0_nx = 2'b11;
                idat1_nx = {^pick_data, pick};
                ready_nx = pick ? 2'b10 : 2'b01;
            end
            S_DATA: begin
                idat0_nx = {shreg_nx[2], shreg_nx[0]};
                idat1_nx = {shreg_nx[3], shreg_nx[1]};
            end
            default: begin
            end
        endcase
        itxen_nx     = (state_nx != S_OFF);
        idataselb_nx = (state_nx == S_OFF);
        link_rdy_nx  = (state_nx == S_IDLE) || (state_nx == S_HDR) ||
                       (state_nx == S_DATA) || (state_nx == S_GAP);
        busy_nx      = (state_nx == S_HDR) || (state_nx == S_DATA) ||
                       (state_nx == S_GAP);
    end

    always_ff @(posedge avmm_clk or negedge avmm_sync_rstb) begin
        if (!avmm_sync_rstb) begin
            state         <= S_OFF;
            warm_cnt      <= 8'd0;
            gap_cnt       <= 4'd0;
            beat          <= '0;
            grant         <= 1'b0;
            last_grant    <= 1'b1;
            shreg         <= '0;
            frame_cnt     <= 8'd0;
            avmm2_idat0   <= 2'b00;
            avmm2_idat1   <= 2'b00;
            req.req_ready <= 2'b00;
            itxen         <= 1'b0;
            idataselb     <= 1'b1;
            link_rdy      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_nx;
            warm_cnt      <= warm_cnt_nx;
            gap_cnt       <= gap_cnt_nx;
            beat          <= beat_nx;
            grant         <= grant_nx;
            last_grant    <= last_grant_nx;
            shreg         <= shreg_nx;
            frame_cnt     <= frame_cnt_nx;
            avmm2_idat0   <= idat0_nx;
            avmm2_idat1   <= idat1_nx;
            req.req_ready <= ready_nx;
            itxen         <= itxen_nx;
            idataselb     <= idataselb_nx;
            link_rdy      <= link_rdy_nx;
            busy          <= busy_nx;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aibnd_avmm2_txsched.sv
// ----------------------------------------------------------------------------
// tb_aibnd_avmm2_txsched : directed self-checking bench for the AVMM2 TX scheduler
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_aibnd_avmm2_txsched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstb;
    logic link_en_a, link_en_b;

    aibnd_avmm2_txsched_if #(.DATA_W(16)) ifa ();
    aibnd_avmm2_txsched_if #(.DATA_W(16)) ifb ();

    logic [1:0] idat0_a, idat1_a, idat0_b, idat1_b;
    logic       itxen_a, seldb_a, rdy_a, busy_a;
    logic       itxen_b, seldb_b, rdy_b, busy_b;
    logic [7:0] fcnt_a, fcnt_b;

    // A: gap of one idle beat; B: no gap, short warm-up
    aibnd_avmm2_txsched #(.DATA_W(16), .WARM_CYC(8), .GAP_CYC(1)) u_dut_a (
        .avmm_clk       (clk),
        .avmm_sync_rstb (rstb),
        .link_en        (link_en_a),
        .req            (ifa),
        .avmm2_idat0    (idat0_a),
        .avmm2_idat1    (idat1_a),
        .itxen          (itxen_a),
        .idataselb      (seldb_a),
        .link_rdy       (rdy_a),
        .busy           (busy_a),
        .frame_cnt      (fcnt_a)
    );

    aibnd_avmm2_txsched #(.DATA_W(16), .WARM_CYC(2), .GAP_CYC(0)) u_dut_b (
        .avmm_clk       (clk),
        .avmm_sync_rstb (rstb),
        .link_en        (link_en_b),
        .req            (ifb),
        .avmm2_idat0    (idat0_b),
        .avmm2_idat1    (idat1_b),
        .itxen          (itxen_b),
        .idataselb      (seldb_b),
        .link_rdy       (rdy_b),
        .busy           (busy_b),
        .frame_cnt      (fcnt_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_pads_a(input string tag, input logic [1:0] e0, input logic [1:0] e1);
        chk({tag, ".idat0"}, 32'(idat0_a), 32'(e0));
        chk({tag, ".idat1"}, 32'(idat1_a), 32'(e1));
    endtask

    initial begin
        rstb          = 1'b0;
        link_en_a     = 1'b0;
        link_en_b     = 1'b0;
        ifa.req_valid = 2'b00;
        ifa.req_data0 = 16'h0000;
        ifa.req_data1 = 16'h0000;
        ifb.req_valid = 2'b00;
        ifb.req_data0 = 16'h0000;
        ifb.req_data1 = 16'h0000;
        step(2);

        // Reset values
        chk_pads_a("rst", 2'b00, 2'b00);
        chk("rst.itxen",     32'(itxen_a), 32'd0);
        chk("rst.idataselb", 32'(seldb_a), 32'd1);
        chk("rst.ready",     32'(ifa.req_ready), 32'd0);
        chk("rst.link_rdy",  32'(rdy_a), 32'd0);
        chk("rst.busy",      32'(busy_a), 32'd0);
        chk("rst.frame_cnt", 32'(fcnt_a), 32'd0);
        rstb = 1'b1;
        step(1);
        chk("off.itxen", 32'(itxen_a), 32'd0);

        // Bring-up: link_en at cycle 0, WARM cycles 1..8, IDLE from cycle 9
        link_en_a = 1'b1;
        step(1);
        chk("warm1.itxen",     32'(itxen_a), 32'd1);
        chk("warm1.idataselb", 32'(seldb_a), 32'd0);
        chk("warm1.link_rdy",  32'(rdy_a), 32'd0);
        chk_pads_a("warm1", 2'b00, 2'b00);
        step(7);
        chk("warm8.link_rdy",  32'(rdy_a), 32'd0);
        step(1);
        chk("idle.link_rdy",   32'(rdy_a), 32'd1);
        chk("idle.busy",       32'(busy_a), 32'd0);

        // Single frame 16'hA5C3 from requester 0: nibbles 3,C,5,A
        ifa.req_data0 = 16'hA5C3;
        ifa.req_valid = 2'b01;
        step(1);
        chk_pads_a("sf.hdr", 2'b11, 2'b00);
        chk("sf.hdr.ready", 32'(ifa.req_ready), 32'h1);
        chk("sf.hdr.busy",  32'(busy_a), 32'd1);
        step(1);
        ifa.req_valid = 2'b00;
        chk_pads_a("sf.b0", 2'b01, 2'b01);
        chk("sf.b0.ready", 32'(ifa.req_ready), 32'h0);
        step(1);
        chk_pads_a("sf.b1", 2'b10, 2'b10);
        step(1);
        chk_pads_a("sf.b2", 2'b11, 2'b00);
        step(1);
        chk_pads_a("sf.b3", 2'b00, 2'b11);
        chk("sf.b3.ready", 32'(ifa.req_ready), 32'h0);
        step(1);
        chk_pads_a("sf.gap", 2'b00, 2'b00);
        chk("sf.gap.busy",      32'(busy_a), 32'd1);
        chk("sf.gap.frame_cnt", 32'(fcnt_a), 32'd1);
        step(1);
        chk("sf.idle.busy", 32'(busy_a), 32'd0);

        // Arbitration: requester 0 was served last, so 1 goes first; 6-cycle spacing.
        // data0=1234 has odd parity, data1=00FF has even parity.
        ifa.req_data0 = 16'h1234;
        ifa.req_data1 = 16'h00FF;
        ifa.req_valid = 2'b11;
        step(1);
        for (int f = 0; f < 4; f++) begin
            logic [1:0] exp_id1;
            logic [1:0] exp_rdy;
            exp_id1 = (f % 2 == 0) ? 2'b01 : 2'b10;
            exp_rdy = (f % 2 == 0) ? 2'b10 : 2'b01;
            chk_pads_a($sformatf("arb%0d.hdr", f), 2'b11, exp_id1);
            chk($sformatf("arb%0d.ready", f), 32'(ifa.req_ready), 32'(exp_rdy));
            if (f < 3) step(6);
        end
        step(1);
        ifa.req_valid = 2'b00;
        step(5);
        chk("arb.idle.busy",      32'(busy_a), 32'd0);
        chk("arb.idle.frame_cnt", 32'(fcnt_a), 32'd5);

        // Drain: link_en drops in beat 1; 9F0F last nibble 9 -> idat0=01 idat1=10
        ifa.req_data0 = 16'h9F0F;
        ifa.req_valid = 2'b01;
        step(1);
        chk("dr.hdr.ready", 32'(ifa.req_ready), 32'h1);
        step(1);
        ifa.req_data1 = 16'h5555;
        ifa.req_valid = 2'b10;
        step(1);
        link_en_a = 1'b0;
        step(1);
        chk("dr.b2.itxen", 32'(itxen_a), 32'd1);
        chk("dr.b2.ready", 32'(ifa.req_ready), 32'h0);
        step(1);
        chk("dr.b3.itxen", 32'(itxen_a), 32'd1);
        chk_pads_a("dr.b3", 2'b01, 2'b10);
        step(1);
        chk("dr.off.itxen",     32'(itxen_a), 32'd0);
        chk("dr.off.idataselb", 32'(seldb_a), 32'd1);
        chk("dr.off.ready",     32'(ifa.req_ready), 32'h0);
        chk("dr.off.link_rdy",  32'(rdy_a), 32'd0);
        chk("dr.off.frame_cnt", 32'(fcnt_a), 32'd6);
        step(2);
        chk("dr.off2.ready", 32'(ifa.req_ready), 32'h0);
        ifa.req_valid = 2'b00;

        // Back-to-back, no gap: 0001 -> header idat1 = {parity 1, id 1}
        link_en_b = 1'b1;
        step(3);
        chk("b2b.idle.link_rdy", 32'(rdy_b), 32'd1);
        ifb.req_data1 = 16'h0001;
        ifb.req_valid = 2'b10;
        step(1);
        chk("b2b.hdr1.idat0", 32'(idat0_b), 32'h3);
        chk("b2b.hdr1.idat1", 32'(idat1_b), 32'h3);
        chk("b2b.hdr1.ready", 32'(ifb.req_ready), 32'h2);
        step(1);
        chk("b2b.b0.idat0", 32'(idat0_b), 32'h1);
        chk("b2b.b0.idat1", 32'(idat1_b), 32'h0);
        step(3);
        chk("b2b.b3.idat0", 32'(idat0_b), 32'h0);
        chk("b2b.b3.busy",  32'(busy_b), 32'd1);
        step(1);
        chk("b2b.hdr2.idat0", 32'(idat0_b), 32'h3);
        chk("b2b.hdr2.idat1", 32'(idat1_b), 32'h3);
        chk("b2b.hdr2.ready", 32'(ifb.req_ready), 32'h2);
        step(1);
        ifb.req_valid = 2'b00;
        step(4);
        chk("b2b.idle.busy",      32'(busy_b), 32'd0);
        chk("b2b.idle.frame_cnt", 32'(fcnt_b), 32'd2);

        // Asynchronous reset in the middle of a frame on B
        ifb.req_data0 = 16'hFFFF;
        ifb.req_valid = 2'b01;
        step(3);
        chk("mr.b1.busy", 32'(busy_b), 32'd1);
        #2;
        rstb = 1'b0;
        #1;
        chk("mr.idat0",     32'(idat0_b), 32'h0);
        chk("mr.idat1",     32'(idat1_b), 32'h0);
        chk("mr.itxen",     32'(itxen_b), 32'd0);
        chk("mr.idataselb", 32'(seldb_b), 32'd1);
        chk("mr.busy",      32'(busy_b), 32'd0);
        chk("mr.link_rdy",  32'(rdy_b), 32'd0);
        chk("mr.frame_cnt", 32'(fcnt_b), 32'd0);
        chk("mr.ready",     32'(ifb.req_ready), 32'h0);
        ifb.req_valid = 2'b00;
        link_en_b     = 1'b0;
        step(1);
        rstb = 1'b1;
        step(1);

        // Counter wrap: 256 frames on A with requester 0 held, 6 cycles each
        link_en_a = 1'b1;
        step(9);
        chk("wr.idle.link_rdy", 32'(rdy_a), 32'd1);
        ifa.req_data0 = 16'h3C3C;
        ifa.req_valid = 2'b01;
        step(1530);
        chk("wr.255.frame_cnt", 32'(fcnt_a), 32'd255);
        chk("wr.255.busy",      32'(busy_a), 32'd1);
        step(6);
        chk("wr.wrap.frame_cnt", 32'(fcnt_a), 32'd0);
        ifa.req_valid = 2'b00;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
